// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: who owns a read and
// the tag that travels alongside it until the RAM returns data.
package mem_arb_pkg;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } resp_tag_t;

    localparam resp_tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_I};

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the RAM command/return
// signals. The arbiter uses the slave view; the core and RAM use the master view.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic            i_gnt;
    logic            i_rvalid;
    logic [DW-1:0]   i_rdata;

    logic            d_req;
    logic            d_we;
    logic [DW/8-1:0] d_be;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [DW-1:0]   d_rdata;

    logic            m_en;
    logic            m_we;
    logic [DW/8-1:0] m_be;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [DW-1:0]   m_rdata;

    logic            busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output m_en, m_we, m_be, m_addr, m_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  m_en, m_we, m_be, m_addr, m_wdata, busy
    );

endinterface

// File: rtl/mem_arbiter_resp_tag_pipe.sv
// Fixed-latency shift register of read tags; the last stage lines up with the
// cycle in which the RAM presents the data for that read.
module resp_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic      CLOCK,
    input  logic      RST,
    input  resp_tag_t tag_in,
    output resp_tag_t tag_out,
    output logic      any_valid
);

    resp_tag_t         stage_reg [RD_LAT];
    logic [RD_LAT-1:0] valid_vec;

    // No backpressure: every stage advances every cycle.
    always_ff @(posedge CLOCK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_reg[i] <= TAG_IDLE;
            end
        end else begin
            stage_reg[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_valid
            assign valid_vec[gi] = stage_reg[gi].valid;
        end
    endgenerate

    assign tag_out   = stage_reg[RD_LAT-1];
    assign any_valid = |valid_vec;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store. Data wins
// ties until it has won MAX_D_STREAK times in a row over a waiting fetch.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int RD_LAT       = 1,
    parameter int MAX_D_STREAK = 4
) (
    input  logic          CLOCK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int BW = DW / 8;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [SW-1:0] streak_reg;
    logic [SW-1:0] streak_next;
    logic          fetch_win;
    logic          data_win;

    logic          cmd_we;
    logic [BW-1:0] cmd_be;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;

    resp_tag_t     tag_in;
    resp_tag_t     tag_out;
    logic          tags_busy;

    // Grants are forced low while reset is held so nothing reaches the RAM.
    always_comb begin
        fetch_win = 1'b0;
        data_win  = 1'b0;
        if (!RST) begin
            if (bus.d_req && !(bus.i_req && streak_reg == STREAK_MAX)) begin
                data_win = 1'b1;
            end else if (bus.i_req) begin
                fetch_win = 1'b1;
            end
        end
    end

    always_comb begin
        streak_next = '0;
        if (data_win && bus.i_req) begin
            streak_next = (streak_reg == STREAK_MAX) ? streak_reg : streak_reg + SW'(1);
        end
    end

    always_ff @(posedge CLOCK or posedge RST) begin
        if (RST) begin
            streak_reg <= '0;
        end else begin
            streak_reg <= streak_next;
        end
    end

    always_comb begin
        cmd_we    = 1'b0;
        cmd_be    = '0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        if (data_win) begin
            cmd_we    = bus.d_we;
            cmd_be    = bus.d_be;
            cmd_addr  = bus.d_addr;
            cmd_wdata = bus.d_wdata;
        end else if (fetch_win) begin
            cmd_be    = '1;
            cmd_addr  = bus.i_addr;
        end
    end

    assign bus.i_gnt   = fetch_win;
    assign bus.d_gnt   = data_win;
    assign bus.m_en    = fetch_win | data_win;
    assign bus.m_we    = cmd_we;
    assign bus.m_be    = cmd_be;
    assign bus.m_addr  = cmd_addr;
    assign bus.m_wdata = cmd_wdata;

    always_comb begin
        tag_in.valid = (fetch_win | data_win) & ~cmd_we;
        tag_in.owner = data_win ? OWN_D : OWN_I;
    end

    resp_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_resp_tag_pipe (
        .CLOCK     (CLOCK),
        .RST       (RST),
        .tag_in    (tag_in),
        .tag_out   (tag_out),
        .any_valid (tags_busy)
    );

    // Both read ports see the RAM bus directly; rvalid says whose data it is.
    assign bus.i_rvalid = tag_out.valid && (tag_out.owner == OWN_I);
    assign bus.d_rvalid = tag_out.valid && (tag_out.owner == OWN_D);
    assign bus.i_rdata  = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;

    assign bus.busy = ~RST & (bus.i_req | bus.d_req | tags_busy);

endmodule
